// File: rtl/dmem_responder_if.sv
// Processor-to-data-memory request/response channel used by dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_access;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_access, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_access, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: accepts one load/store, waits a fixed
// number of cycles, commits to a little-endian byte store and presents one response.
module dmem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 512
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_WORD = 2'b10;

  // Misaligned halves/words and the reserved size code are all rejected.
  function automatic logic access_err(input logic [1:0] acc, input logic [1:0] lsb);
    logic e;
    case (acc)
      ACC_BYTE: e = 1'b0;
      ACC_HALF: e = lsb[0];
      ACC_WORD: e = (lsb != 2'b00);
      default:  e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] acc,
                                              input logic uns);
    logic [31:0] r;
    case (acc)
      ACC_BYTE: r = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      ACC_HALF: r = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      ACC_WORD: r = w;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        req_ready_r;
  logic        busy_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        we_r;
  logic [8:0]  addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  access_r;
  logic        unsigned_r;
  logic        err_r;
  logic [31:0] rd_word_r;

  logic [7:0]  mem [DEPTH];

  logic        accept_s;
  logic        commit_s;
  logic [8:0]  a1_s;
  logic [8:0]  a2_s;
  logic [8:0]  a3_s;

  assign accept_s = bus.req_valid && req_ready_r;
  assign commit_s = (state_r == WAIT) && (cnt_r == 4'd0);
  assign a1_s     = addr_r + 9'd1;
  assign a2_s     = addr_r + 9'd2;
  assign a3_s     = addr_r + 9'd3;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign busy          = busy_r;

  // Control FSM with registered handshake outputs; the first RESP cycle formats the load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 9'd0;
      wdata_r     <= 32'd0;
      access_r    <= 2'b00;
      unsigned_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r        <= bus.req_we;
            addr_r      <= bus.req_addr;
            wdata_r     <= bus.req_wdata;
            access_r    <= bus.req_access;
            unsigned_r  <= bus.req_unsigned;
            err_r       <= access_err(bus.req_access, bus.req_addr[1:0]);
            cnt_r       <= 4'(WAIT_STATES);
            state_r     <= WAIT;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= RESP;
          end
        end
        RESP: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_r;
            rsp_rdata_r <= (err_r || we_r) ? 32'd0 : load_extend(rd_word_r, access_r, unsigned_r);
          end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Byte store: not reset, so contents survive a reset; alignment keeps halves/words in range.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      rd_word_r <= {mem[a3_s], mem[a2_s], mem[a1_s], mem[addr_r]};
      if (we_r && !err_r) begin
        case (access_r)
          ACC_BYTE: begin
            mem[addr_r] <= wdata_r[7:0];
          end
          ACC_HALF: begin
            mem[addr_r] <= wdata_r[7:0];
            mem[a1_s]   <= wdata_r[15:8];
          end
          ACC_WORD: begin
            mem[addr_r] <= wdata_r[7:0];
            mem[a1_s]   <= wdata_r[15:8];
            mem[a2_s]   <= wdata_r[23:16];
            mem[a3_s]   <= wdata_r[31:24];
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
